sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller port inside the guest core between three requesters: video fetch (port 0), CPU (port 1) and the SPI/IO loader that downloads ROM images from the ARM controller (port 2).
- Sits between the requesters and the SDRAM controller.
- Serialises one word transaction at a time using fixed priority with a starvation override.
- Registers the winner's command onto the controller port and routes the completion back to that requester.

Parameters:
- ADDR_W, 24, word address width (32 MB, 16-bit SDRAM).
- DATA_W, 16, data width.
- STARVE_LIMIT, 8, number of lost arbitrations before port 1 or port 2 is forced to top priority.

Ports:
- clk  in  1  system clock; sole clock domain.
- reset  in  1  synchronous, active-high reset.
- req[2:0]  in  3  per-port request level; bit n = port n.
- we[2:0]  in  3  per-port write enable (1 = write).
- addr0/addr1/addr2  in  ADDR_W each  per-port word address.
- wdata0/wdata1/wdata2  in  DATA_W each  per-port write data.
- bsel0/bsel1/bsel2  in  2 each  per-port byte enables [1]=high byte, [0]=low byte; active-high.
- ack[2:0]  out  3  one-cycle completion pulse per port.
- rdata  out  DATA_W  read data, shared; valid only in the cycle an ack bit is high.
- mem_req  out  1  command valid to the SDRAM controller.
- mem_we  out  1  write enable to the controller.
- mem_addr  out  ADDR_W  address to the controller.
- mem_wdata  out  DATA_W  write data to the controller.
- mem_dqm  out  2  byte masks; mem_dqm = ~bsel of the granted port, so active-low.
- mem_ack  in  1  completion pulse from the controller; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  read data from the controller.
- grant  out  2  port owning the current transaction; 2'b11 = none.
- busy  out  1  high in BUSY and DONE.

Behaviour:
- Reset values: all outputs are 0, except mem_dqm = 2'b11 and grant = 2'b11. State = IDLE. Both starvation counters = 0.
- Requester protocol:
  - Hold req high with we/addr/wdata/bsel stable until ack is seen.
  - req still high in the cycle after ack means a new transaction.
  - Dropping req before ack is a protocol violation. The arbiter still completes the transaction and pulses ack.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any req bit is set, select a winner.
  - On the next edge, register the winner's fields onto mem_*, set mem_req=1, set grant, and go to BUSY.
  - If no req bit is set, stay in IDLE with mem_req=0 and grant=2'b11.
- BUSY:
  - Hold mem_req and all mem_* fields stable.
  - On mem_ack=1: register mem_rdata into rdata, set ack[grant]=1, clear mem_req, go to DONE.
- DONE:
  - ack is high for exactly this cycle; clear it on exit.
  - rdata holds its value until the next completion.
  - Return to IDLE and set grant=2'b11.
- Latency:
  - req sampled high at edge k gives mem_req=1 from cycle k+1.
  - mem_ack at cycle m gives ack at cycle m+1.
  - The earliest next mem_req is cycle m+3.
- Winner selection, in order:
  1. If starve1 >= STARVE_LIMIT and req[1]: port 1.
  2. Else if starve2 >= STARVE_LIMIT and req[2]: port 2.
  3. Otherwise fixed priority: 0 > 1 > 2.
- Starvation counters:
  - Evaluated at every IDLE selection. For ports 1 and 2, if req is high and the port is not selected, increment its counter, saturating at STARVE_LIMIT.
  - When a port is selected, its counter clears to 0.
  - A counter is unchanged whenever its port's req is low.
  - Port 0 has no counter.
- mem_ack while in IDLE or DONE is ignored.
- mem_ack on the same edge BUSY is entered is impossible, because mem_req was not yet visible. No special handling is required.
- reset asserted mid-transaction: outputs return to reset values on the next edge and the transaction is abandoned. The controller must tolerate mem_req falling.
- Reads ignore bsel; mem_dqm is still driven from it.

Test Plan:
- Single read: reset, then req=3'b010, addr1=24'h000123, we=0. Expect:
  - mem_req rises one cycle later with mem_addr=24'h000123 and grant=1.
  - Drive mem_ack with mem_rdata=16'hBEEF. Next cycle ack=3'b010 and rdata=16'hBEEF.
- Write with byte mask: port 2, we=1, wdata2=16'h5A5A, bsel2=2'b01. Expect mem_we=1, mem_wdata=16'h5A5A, mem_dqm=2'b10.
- Priority: req=3'b111 asserted together. Expect the grant order 0, 1, 2 across three transactions, each with an ack on the correct bit only.
- Starvation: hold req[0] continuously (re-requesting after every ack) and hold req[1]. Expect port 1 granted after exactly 8 port-0 grants, then its counter resets.
- Reset mid-BUSY: assert reset while mem_req=1. Expect the next cycle to show mem_req=0, grant=2'b11, ack=0, and a later mem_ack to be ignored.
- Back-to-back: keep req[0] high through ack. Expect mem_req to re-rise exactly 2 cycles after the ack cycle.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Three-requester arbiter onto the single SDRAM controller port: fixed priority 0>1>2,
// with a starvation override that lifts port 1 or port 2 to the top after repeated losses.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  input  logic [1:0]        bsel0,
  input  logic [1:0]        bsel1,
  input  logic [1:0]        bsel2,
  output logic [2:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_dqm,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic              busy
);
  localparam int unsigned     CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [1:0]      NO_GRANT = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        mem_dqm_q, mem_dqm_d;
  logic [1:0]        grant_q, grant_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  starve1_q, starve1_d;
  logic [CNT_W-1:0]  starve2_q, starve2_d;

  logic [1:0]        win_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;
  logic [1:0]        sel_bsel_c;

  // Winner: a starved port 1/2 first, else fixed priority.
  always_comb begin : winner_sel
    if (starve1_q >= LIMIT && req[1])      win_c = 2'd1;
    else if (starve2_q >= LIMIT && req[2]) win_c = 2'd2;
    else if (req[0])                       win_c = 2'd0;
    else if (req[1])                       win_c = 2'd1;
    else                                   win_c = 2'd2;
  end

  always_comb begin : field_mux
    sel_we_c    = we[0];
    sel_addr_c  = addr0;
    sel_wdata_c = wdata0;
    sel_bsel_c  = bsel0;
    case (win_c)
      2'd1: begin
        sel_we_c    = we[1];
        sel_addr_c  = addr1;
        sel_wdata_c = wdata1;
        sel_bsel_c  = bsel1;
      end
      2'd2: begin
        sel_we_c    = we[2];
        sel_addr_c  = addr2;
        sel_wdata_c = wdata2;
        sel_bsel_c  = bsel2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      state_q     <= IDLE;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_dqm_q   <= 2'b11;
      grant_q     <= NO_GRANT;
      busy_q      <= 1'b0;
      starve1_q   <= '0;
      starve2_q   <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_dqm_q   <= mem_dqm_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      starve1_q   <= starve1_d;
      starve2_q   <= starve2_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = BUSY;
      BUSY:    if (mem_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : out_comb
    ack_d       = '0;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_dqm_d   = mem_dqm_q;
    grant_d     = grant_q;
    starve1_d   = starve1_q;
    starve2_d   = starve2_q;
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (|req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = sel_we_c;
          mem_addr_d  = sel_addr_c;
          mem_wdata_d = sel_wdata_c;
          mem_dqm_d   = ~sel_bsel_c;
          grant_d     = win_c;
          // Losers that are requesting age toward the override; the winner restarts.
          if (win_c == 2'd1)                      starve1_d = '0;
          else if (req[1] && starve1_q < LIMIT)   starve1_d = starve1_q + CNT_W'(1);
          if (win_c == 2'd2)                      starve2_d = '0;
          else if (req[2] && starve2_q < LIMIT)   starve2_d = starve2_q + CNT_W'(1);
        end
      end
      BUSY: begin
        if (mem_ack) begin
          rdata_d   = mem_rdata;
          ack_d     = 3'b001 << grant_q;
          mem_req_d = 1'b0;
        end
      end
      DONE: grant_d = NO_GRANT;
      default: ;
    endcase
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_dqm   = mem_dqm_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized scoreboard bench for sdram_port_arbiter: a transaction-level arbitration model
// predicts command/completion order; a monitor thread checks the DUT against it.
module tb_sdram_port_arbiter;
  localparam int unsigned LIMIT = 8;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [1:0]  bsel;
  } txn_t;

  typedef struct {
    logic [1:0]  port;
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [1:0]  dqm;
  } cmd_t;

  typedef struct {
    logic [2:0]  ack;
    logic [15:0] rdata;
    bit          more;
  } cmp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, we;
  logic [23:0] addr_a [3];
  logic [15:0] wdata_a [3];
  logic [1:0]  bsel_a [3];
  logic [2:0]  ack;
  logic [15:0] rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0]  mem_dqm, grant;
  logic        busy;

  int checks = 0;
  int errors = 0;

  txn_t stage_q [3][$];
  txn_t port_q  [3][$];
  cmd_t cmd_q [$];
  cmp_t cmp_q [$];
  logic [1:0] obs_grants [$];
  int unsigned st1, st2;
  bit flush, hold_resp, spur_en;
  logic [15:0] last_rdata;
  logic [1:0]  last_dqm;
  int first1, second1;

  sdram_port_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr_a[0]), .addr1(addr_a[1]), .addr2(addr_a[2]),
    .wdata0(wdata_a[0]), .wdata1(wdata_a[1]), .wdata2(wdata_a[2]),
    .bsel0(bsel_a[0]), .bsel1(bsel_a[1]), .bsel2(bsel_a[2]),
    .ack(ack), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_dqm(mem_dqm), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Controller data for any address; 000123 returns BEEF.
  function automatic logic [15:0] mem_fn(input logic [23:0] a);
    return a[15:0] ^ {8'h00, a[23:16]} ^ 16'hBFCC;
  endfunction

  function automatic txn_t mk(input logic w, input logic [23:0] a, input logic [15:0] d,
                              input logic [1:0] b);
    txn_t t;
    t.we = w; t.addr = a; t.wdata = d; t.bsel = b;
    return t;
  endfunction

  function automatic int pick(input bit [2:0] p);
    if (st1 >= LIMIT && p[1]) return 1;
    if (st2 >= LIMIT && p[2]) return 2;
    if (p[0]) return 0;
    if (p[1]) return 1;
    return 2;
  endfunction

  // Reference: every port holds req until its queue drains, so the grant order follows.
  task automatic launch();
    txn_t mq [3][$];
    bit [2:0] pend;
    int w;
    txn_t t;
    cmd_t c;
    cmp_t r;
    for (int p = 0; p < 3; p++) mq[p] = stage_q[p];
    while ((mq[0].size() + mq[1].size() + mq[2].size()) != 0) begin
      pend = {mq[2].size() != 0, mq[1].size() != 0, mq[0].size() != 0};
      w = pick(pend);
      if (pend[1]) st1 = (w == 1) ? 0 : ((st1 < LIMIT) ? st1 + 1 : st1);
      if (pend[2]) st2 = (w == 2) ? 0 : ((st2 < LIMIT) ? st2 + 1 : st2);
      t = mq[w].pop_front();
      c.port = 2'(w); c.we = t.we; c.addr = t.addr; c.wdata = t.wdata; c.dqm = ~t.bsel;
      cmd_q.push_back(c);
      r.ack = 3'(1 << w);
      r.rdata = mem_fn(t.addr);
      r.more = (mq[0].size() + mq[1].size() + mq[2].size()) != 0;
      cmp_q.push_back(r);
    end
    for (int p = 0; p < 3; p++) begin
      port_q[p] = stage_q[p];
      stage_q[p].delete();
    end
  endtask

  task automatic drive_loop();
    forever begin
      @(posedge clk); #1;
      if (flush) begin
        for (int p = 0; p < 3; p++) port_q[p].delete();
        flush = 1'b0;
      end
      for (int p = 0; p < 3; p++)
        if (ack[p] && port_q[p].size() != 0) port_q[p].delete(0);
      for (int p = 0; p < 3; p++) begin
        if (port_q[p].size() != 0) begin
          req[p]     = 1'b1;
          we[p]      = port_q[p][0].we;
          addr_a[p]  = port_q[p][0].addr;
          wdata_a[p] = port_q[p][0].wdata;
          bsel_a[p]  = port_q[p][0].bsel;
        end else begin
          req[p] = 1'b0;
        end
      end
    end
  endtask

  task automatic resp_loop();
    int dly = 0;
    bit done_cmd = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!mem_req) begin
        done_cmd = 1'b0;
        if (spur_en && $urandom_range(0, 3) == 0) begin
          mem_ack = 1'b1;
          mem_rdata = 16'($urandom);
        end
      end else if (!done_cmd && !hold_resp) begin
        if (dly == 0) begin
          mem_ack = 1'b1;
          mem_rdata = mem_fn(mem_addr);
          done_cmd = 1'b1;
          dly = $urandom_range(0, 3);
        end else begin
          dly--;
        end
      end
    end
  endtask

  task automatic mon_loop();
    bit prev_req = 1'b0, prev_hit = 1'b0, exp_rise = 1'b0, more_pend = 1'b0;
    int cyc = 0, ack_cyc = 0;
    cmd_t cur;
    cmp_t r;
    logic [2:0] exp_ack;
    cur.port = 2'b11; cur.we = 1'b0; cur.addr = '0; cur.wdata = '0; cur.dqm = 2'b11;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_req = 1'b0; prev_hit = 1'b0; exp_rise = 1'b0;
        continue;
      end
      if (exp_rise) chk("req_to_mem_req_latency", 64'(mem_req), 64'd1);
      exp_rise = (req != 3'b000) && !busy && !mem_req;

      exp_ack = prev_hit ? 3'(3'b001 << cur.port) : 3'b000;
      chk("ack_timing", 64'(ack), 64'(exp_ack));
      if (ack != 3'b000) begin
        chk("busy_in_done", 64'(busy), 64'd1);
        chk("grant_in_done", 64'(grant), 64'(cur.port));
        if (cmp_q.size() == 0) begin
          chk("unexpected_ack", 64'(ack), 64'd0);
        end else begin
          r = cmp_q.pop_front();
          chk("ack_port", 64'(ack), 64'(r.ack));
          chk("rdata", 64'(rdata), 64'(r.rdata));
          more_pend = r.more;
          ack_cyc = cyc;
          last_rdata = rdata;
        end
      end
      prev_hit = mem_req && mem_ack;

      if (mem_req && !prev_req) begin
        if (cmd_q.size() == 0) begin
          chk("unexpected_cmd", 64'(mem_req), 64'd0);
        end else begin
          cur = cmd_q.pop_front();
        end
        obs_grants.push_back(grant);
        last_dqm = mem_dqm;
        if (more_pend) chk("back_to_back_gap", 64'(cyc - ack_cyc), 64'd2);
        more_pend = 1'b0;
      end
      if (mem_req) begin
        chk("grant", 64'(grant), 64'(cur.port));
        chk("mem_we", 64'(mem_we), 64'(cur.we));
        chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
        chk("mem_dqm", 64'(mem_dqm), 64'(cur.dqm));
        chk("busy_in_busy", 64'(busy), 64'd1);
      end
      prev_req = mem_req;
    end
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((port_q[0].size() + port_q[1].size() + port_q[2].size() +
                 cmd_q.size() + cmp_q.size()) != 0 || busy || mem_req) && n < 3000);
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles, %0d completions outstanding",
               n, cmp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    st1 = 0; st2 = 0;
    cmd_q.delete(); cmp_q.delete();
  endtask

  initial begin
    reset = 1'b1; req = '0; we = '0; mem_ack = 1'b0; mem_rdata = '0;
    for (int p = 0; p < 3; p++) begin addr_a[p] = '0; wdata_a[p] = '0; bsel_a[p] = '0; end
    flush = 1'b0; hold_resp = 1'b0; spur_en = 1'b0; st1 = 0; st2 = 0;
    last_rdata = '0; last_dqm = '0;
    fork
      drive_loop();
      resp_loop();
      mon_loop();
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_mem_dqm", 64'(mem_dqm), 64'd3);
    chk("rst_grant", 64'(grant), 64'd3);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    // Single read on port 1.
    stage_q[1].push_back(mk(1'b0, 24'h000123, 16'h0000, 2'b11));
    launch(); drain();
    chk("single_read_rdata", 64'(last_rdata), 64'h0000_0000_0000_BEEF);

    // Masked write on port 2.
    stage_q[2].push_back(mk(1'b1, 24'h00ABCD, 16'h5A5A, 2'b01));
    launch(); drain();
    chk("write_dqm", 64'(last_dqm), 64'd2);

    // All three together: fixed priority order.
    obs_grants.delete();
    for (int p = 0; p < 3; p++) stage_q[p].push_back(mk(1'($urandom), 24'($urandom), 16'($urandom), 2'($urandom)));
    launch(); drain();
    chk("prio_count", 64'(obs_grants.size()), 64'd3);
    if (obs_grants.size() == 3)
      chk("prio_order", 64'({obs_grants[0], obs_grants[1], obs_grants[2]}), 64'h06);

    // Starvation: port 0 always requesting, port 1 waits.
    do_reset();
    obs_grants.delete();
    for (int i = 0; i < 20; i++) stage_q[0].push_back(mk(1'b0, 24'(i), 16'(i), 2'b11));
    for (int i = 0; i < 2; i++)  stage_q[1].push_back(mk(1'b1, 24'(100 + i), 16'(i), 2'b10));
    launch(); drain();
    first1 = -1; second1 = -1;
    foreach (obs_grants[i])
      if (obs_grants[i] == 2'd1) begin
        if (first1 < 0) first1 = i;
        else if (second1 < 0) second1 = i;
      end
    chk("starve_first_port1_index", 64'(first1), 64'd8);
    chk("starve_second_port1_index", 64'(second1), 64'd17);

    // Reset while the controller is mid-transaction.
    hold_resp = 1'b1;
    stage_q[0].push_back(mk(1'b1, 24'h3456AB, 16'h1234, 2'b11));
    launch();
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    chk("midrst_started", 64'(mem_req), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("midrst_mem_req", 64'(mem_req), 64'd0);
    chk("midrst_grant", 64'(grant), 64'd3);
    chk("midrst_ack", 64'(ack), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    st1 = 0; st2 = 0;
    cmd_q.delete(); cmp_q.delete();
    hold_resp = 1'b0;
    spur_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_stray_ack_ignored", 64'(mem_req), 64'd0);

    // Randomized phases.
    for (int ph = 0; ph < 40; ph++) begin
      spur_en = 1'($urandom);
      for (int p = 0; p < 3; p++) begin
        int n;
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++)
          stage_q[p].push_back(mk(1'($urandom), 24'($urandom), 16'($urandom), 2'($urandom)));
      end
      launch(); drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
